udp_meta_reflector: RTL

- Application stage inside the Themisto ROLE. Sits directly downstream of the NRC UDP receive path and directly upstream of the NRC UDP transmit path.
- Consumes one UDP datagram (80-bit meta + 64-bit AXIS data), stores it whole, then returns it to the sender.
- The returned datagram carries rewritten meta: ranks/ports swapped, length recomputed from received bytes.
- Store-and-forward is mandatory because the TX meta, including len, must precede the TX data.

---
 rtl/udp_meta_reflector.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/udp_meta_reflector.sv
// Store-and-forward UDP echo stage: buffers one RX datagram whole, then returns it
// to the sender with ranks/ports swapped and len recomputed from the received bytes.
module udp_meta_reflector #(
   parameter int unsigned DEPTH            = 256,
   parameter logic [31:0] LISTEN_PORT_MASK = 32'h0000_0001
) (
   input  logic        piSHL_156_25Clk,
   input  logic        piSHL_156_25Rst,
   input  logic        piMMIO_Ly7_En,
   input  logic [31:0] piFMC_ROLE_rank,
   input  logic [79:0] siNRC_Role_Udp_Meta_TDATA,
   input  logic        siNRC_Role_Udp_Meta_TVALID,
   output logic        siNRC_Role_Udp_Meta_TREADY,
   input  logic [9:0]  siNRC_Role_Udp_Meta_TKEEP,
   input  logic        siNRC_Role_Udp_Meta_TLAST,
   input  logic [63:0] siNRC_Udp_Data_tdata,
   input  logic [7:0]  siNRC_Udp_Data_tkeep,
   input  logic        siNRC_Udp_Data_tvalid,
   input  logic        siNRC_Udp_Data_tlast,
   output logic        siNRC_Udp_Data_tready,
   output logic [79:0] soROLE_Nrc_Udp_Meta_TDATA,
   output logic        soROLE_Nrc_Udp_Meta_TVALID,
   input  logic        soROLE_Nrc_Udp_Meta_TREADY,
   output logic [9:0]  soROLE_Nrc_Udp_Meta_TKEEP,
   output logic        soROLE_Nrc_Udp_Meta_TLAST,
   output logic [63:0] soNRC_Udp_Data_tdata,
   output logic [7:0]  soNRC_Udp_Data_tkeep,
   output logic        soNRC_Udp_Data_tvalid,
   output logic        soNRC_Udp_Data_tlast,
   input  logic        soNRC_Udp_Data_tready,
   output logic [31:0] poROL_Nrc_Udp_Rx_ports,
   output logic [15:0] poDropCnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RX   = 2'd1;
   localparam logic [1:0] TXM  = 2'd2;
   localparam logic [1:0] TXD  = 2'd3;

   logic [1:0]    state, stateNext;
   logic [PW-1:0] wptr, wptrNext, rptr, rptrNext;
   logic [15:0]   byteCnt, byteCntNext;
   logic          ovf, ovfNext;
   logic [15:0]   dropCnt, dropCntNext;
   logic [7:0]    capSrcRank, capSrcRankNext;
   logic [15:0]   capDstPort, capDstPortNext;
   logic [15:0]   capSrcPort, capSrcPortNext;

   logic          rxMetaRdy, rxMetaRdyNext;
   logic          rxDataRdy, rxDataRdyNext;
   logic          txMetaValid, txMetaValidNext;
   logic [79:0]   txMetaData, txMetaDataNext;
   logic [9:0]    txMetaKeep;
   logic          txMetaLast;
   logic          txDataValid, txDataValidNext;
   logic          txDataLast, txDataLastNext;
   logic [63:0]   txData;
   logic [7:0]    txKeep;

   logic          memWe, memRe;
   logic [AW-1:0] memRaddr;
   logic [71:0]   mem [DEPTH];

   logic metaHs, dataHs, txMetaHs, txDataHs;
   logic unusedSig;

   function automatic logic [3:0] popCount(input logic [7:0] k);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + 4'(k[i]);
      return n;
   endfunction

   assign metaHs   = siNRC_Role_Udp_Meta_TVALID & rxMetaRdy;
   assign dataHs   = siNRC_Udp_Data_tvalid & rxDataRdy;
   assign txMetaHs = txMetaValid & soROLE_Nrc_Udp_Meta_TREADY;
   assign txDataHs = txDataValid & soNRC_Udp_Data_tready;

   // Next-state and next-output logic
   always_comb begin
      stateNext       = state;
      wptrNext        = wptr;
      rptrNext        = rptr;
      byteCntNext     = byteCnt;
      ovfNext         = ovf;
      dropCntNext     = dropCnt;
      capSrcRankNext  = capSrcRank;
      capDstPortNext  = capDstPort;
      capSrcPortNext  = capSrcPort;
      txMetaValidNext = txMetaValid;
      txMetaDataNext  = txMetaData;
      txDataValidNext = txDataValid;
      txDataLastNext  = txDataLast;
      memWe           = 1'b0;
      memRe           = 1'b0;
      memRaddr        = rptr[AW-1:0];

      case (state)
         IDLE: begin
            if (metaHs) begin
               capSrcRankNext = siNRC_Role_Udp_Meta_TDATA[15:8];
               capDstPortNext = siNRC_Role_Udp_Meta_TDATA[31:16];
               capSrcPortNext = siNRC_Role_Udp_Meta_TDATA[47:32];
               wptrNext       = '0;
               byteCntNext    = '0;
               ovfNext        = 1'b0;
               stateNext      = RX;
            end
         end
         RX: begin
            if (dataHs) begin
               // Once the buffer is full every remaining beat of the datagram is dropped
               if (ovf || (wptr == PW'(DEPTH))) begin
                  ovfNext = 1'b1;
               end else begin
                  memWe       = 1'b1;
                  wptrNext    = wptr + PW'(1);
                  byteCntNext = byteCnt + 16'(popCount(siNRC_Udp_Data_tkeep));
               end
               if (siNRC_Udp_Data_tlast) begin
                  if (ovfNext) begin
                     if (dropCnt != 16'hFFFF) dropCntNext = dropCnt + 16'd1;
                     stateNext = IDLE;
                  end else begin
                     txMetaValidNext = 1'b1;
                     txMetaDataNext  = {16'h0000, byteCntNext, capDstPort, capSrcPort,
                                        piFMC_ROLE_rank[7:0], capSrcRank};
                     stateNext       = TXM;
                  end
               end
            end
         end
         TXM: begin
            if (txMetaHs) begin
               txMetaValidNext = 1'b0;
               rptrNext        = '0;
               memRe           = 1'b1;
               memRaddr        = '0;
               txDataValidNext = 1'b1;
               txDataLastNext  = (wptr == PW'(1));
               stateNext       = TXD;
            end
         end
         default: begin
            if (txDataHs) begin
               if (txDataLast) begin
                  txDataValidNext = 1'b0;
                  txDataLastNext  = 1'b0;
                  stateNext       = IDLE;
               end else begin
                  // Prefetch the following word so beats can stream every cycle
                  rptrNext       = rptr + PW'(1);
                  memRe          = 1'b1;
                  memRaddr       = rptrNext[AW-1:0];
                  txDataLastNext = (rptrNext == (wptr - PW'(1)));
               end
            end
         end
      endcase

      rxMetaRdyNext = (stateNext == IDLE) && piMMIO_Ly7_En;
      rxDataRdyNext = (stateNext == RX);
   end

   // State and registered outputs
   always_ff @(posedge piSHL_156_25Clk or posedge piSHL_156_25Rst) begin
      if (piSHL_156_25Rst) begin
         state       <= IDLE;
         wptr        <= '0;
         rptr        <= '0;
         byteCnt     <= '0;
         ovf         <= 1'b0;
         dropCnt     <= '0;
         capSrcRank  <= '0;
         capDstPort  <= '0;
         capSrcPort  <= '0;
         rxMetaRdy   <= 1'b0;
         rxDataRdy   <= 1'b0;
         txMetaValid <= 1'b0;
         txMetaData  <= '0;
         txMetaKeep  <= '0;
         txMetaLast  <= 1'b0;
         txDataValid <= 1'b0;
         txDataLast  <= 1'b0;
         txData      <= '0;
         txKeep      <= '0;
      end else begin
         state       <= stateNext;
         wptr        <= wptrNext;
         rptr        <= rptrNext;
         byteCnt     <= byteCntNext;
         ovf         <= ovfNext;
         dropCnt     <= dropCntNext;
         capSrcRank  <= capSrcRankNext;
         capDstPort  <= capDstPortNext;
         capSrcPort  <= capSrcPortNext;
         rxMetaRdy   <= rxMetaRdyNext;
         rxDataRdy   <= rxDataRdyNext;
         txMetaValid <= txMetaValidNext;
         txMetaData  <= txMetaDataNext;
         txMetaKeep  <= txMetaValidNext ? 10'h3FF : 10'h000;
         txMetaLast  <= txMetaValidNext;
         txDataValid <= txDataValidNext;
         txDataLast  <= txDataLastNext;
         if (memRe) {txKeep, txData} <= mem[memRaddr];
      end
   end

   always_ff @(posedge piSHL_156_25Clk) begin
      if (memWe) mem[wptr[AW-1:0]] <= {siNRC_Udp_Data_tkeep, siNRC_Udp_Data_tdata};
   end

   assign siNRC_Role_Udp_Meta_TREADY = rxMetaRdy;
   assign siNRC_Udp_Data_tready      = rxDataRdy;
   assign soROLE_Nrc_Udp_Meta_TDATA  = txMetaData;
   assign soROLE_Nrc_Udp_Meta_TVALID = txMetaValid;
   assign soROLE_Nrc_Udp_Meta_TKEEP  = txMetaKeep;
   assign soROLE_Nrc_Udp_Meta_TLAST  = txMetaLast;
   assign soNRC_Udp_Data_tdata       = txData;
   assign soNRC_Udp_Data_tkeep       = txKeep;
   assign soNRC_Udp_Data_tvalid      = txDataValid;
   assign soNRC_Udp_Data_tlast       = txDataLast;
   assign poROL_Nrc_Udp_Rx_ports     = LISTEN_PORT_MASK;
   assign poDropCnt                  = dropCnt;

   assign unusedSig = ^{piFMC_ROLE_rank[31:8], siNRC_Role_Udp_Meta_TDATA[79:48],
                        siNRC_Role_Udp_Meta_TDATA[7:0], siNRC_Role_Udp_Meta_TKEEP,
                        siNRC_Role_Udp_Meta_TLAST};

endmodule
